// File: rtl/fc_layer_ctrl_pkg.sv
// Shared types and width helpers for the fully-connected layer controller.
// The width functions keep every counter at least one bit wide for degenerate sizes.
package fc_ctrl_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } fc_state_t;

    function automatic int k_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int g_width(input int m, input int p);
        return $clog2(m / p) + 1;
    endfunction

    function automatic int j_width(input int p);
        return $clog2(p) + 1;
    endfunction

    function automatic int w_width(input int m, input int n, input int p);
        return ((m * n / p) > 1) ? $clog2(m * n / p) : 1;
    endfunction

endpackage

// File: rtl/fc_layer_ctrl_addr_gen.sv
// Input-index (k) and output-group (g) counters with the derived x / weight addresses.
// The weight base advances by N per group so no multiplier is needed.
module fc_addr_gen
    import fc_ctrl_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 8,
    parameter int P = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        k_step,
    input  logic                        g_step,
    input  logic                        g_clr,
    output logic [k_width(N)-1:0]       addr_x,
    output logic [w_width(M,N,P)-1:0]   addr_w,
    output logic                        k_first,
    output logic                        k_last,
    output logic                        g_last
);

    localparam int KW = k_width(N);
    localparam int GW = g_width(M, P);
    localparam int AW = w_width(M, N, P);

    logic [KW-1:0] k_reg, k_next;
    logic [GW-1:0] g_reg, g_next;
    logic [AW-1:0] base_reg, base_next;

    assign k_first = (k_reg == '0);
    assign k_last  = (k_reg == KW'(N - 1));
    assign g_last  = (g_reg == GW'(M / P - 1));

    always_comb begin
        k_next    = k_reg;
        g_next    = g_reg;
        base_next = base_reg;
        if (k_step) begin
            k_next = k_last ? '0 : k_reg + KW'(1);
        end
        if (g_clr) begin
            g_next    = '0;
            base_next = '0;
        end else if (g_step) begin
            g_next    = g_reg + GW'(1);
            base_next = base_reg + AW'(N);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_reg    <= '0;
            g_reg    <= '0;
            base_reg <= '0;
        end else begin
            k_reg    <= k_next;
            g_reg    <= g_next;
            base_reg <= base_next;
        end
    end

    assign addr_x = k_reg;
    assign addr_w = base_reg + AW'(k_reg);

endmodule

// File: rtl/fc_layer_ctrl.sv
// Sequencer for one M x N fully-connected layer with P MAC lanes: load x, sweep
// the weight ROM per output group, then stream the P lane results out.
module fc_layer_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 8,
    parameter int T = 16,
    parameter int P = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        input_valid,
    output logic                        input_ready,
    output logic                        output_valid,
    input  logic                        output_ready,
    output logic [k_width(N)-1:0]       addr_x,
    output logic                        wr_en_x,
    output logic [w_width(M,N,P)-1:0]   addr_w,
    output logic                        clear_acc,
    output logic                        en_acc,
    output logic [P-1:0]                f_sel
);

    localparam int JW = j_width(P);

    fc_state_t state_reg, state_next;
    logic [JW-1:0] j_reg, j_next;

    logic k_step, g_step, g_clr;
    logic k_first, k_last, g_last;
    logic j_last;

    // Data width only matters to the datapath; kept here so generated tops can pass it uniformly.
    logic [T-1:0] unused_t_probe;
    assign unused_t_probe = '0;

    fc_addr_gen #(
        .M (M),
        .N (N),
        .P (P)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .k_step  (k_step),
        .g_step  (g_step),
        .g_clr   (g_clr),
        .addr_x  (addr_x),
        .addr_w  (addr_w),
        .k_first (k_first),
        .k_last  (k_last),
        .g_last  (g_last)
    );

    assign j_last = (j_reg == JW'(P - 1));

    always_comb begin
        state_next   = state_reg;
        j_next       = j_reg;
        input_ready  = 1'b0;
        output_valid = 1'b0;
        wr_en_x      = 1'b0;
        clear_acc    = 1'b0;
        en_acc       = 1'b0;
        k_step       = 1'b0;
        g_step       = 1'b0;
        g_clr        = 1'b0;
        case (state_reg)
            LOAD: begin
                input_ready = 1'b1;
                wr_en_x     = input_valid;
                if (input_valid) begin
                    k_step = 1'b1;
                    if (k_last) begin
                        g_clr      = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Enable trails the address by one cycle to line up with the registered reads.
                k_step    = 1'b1;
                clear_acc = k_first;
                en_acc    = ~k_first;
                if (k_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                en_acc     = 1'b1;
                j_next     = '0;
                state_next = OUT;
            end
            OUT: begin
                output_valid = 1'b1;
                if (output_ready) begin
                    if (!j_last) begin
                        j_next = j_reg + JW'(1);
                    end else begin
                        j_next = '0;
                        if (!g_last) begin
                            g_step     = 1'b1;
                            state_next = ISSUE;
                        end else begin
                            g_clr      = 1'b1;
                            state_next = LOAD;
                        end
                    end
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= LOAD;
            j_reg     <= '0;
        end else begin
            state_reg <= state_next;
            j_reg     <= j_next;
        end
    end

    for (genvar gi = 0; gi < P; gi++) begin : g_fsel
        assign f_sel[gi] = (j_reg == JW'(gi));
    end

endmodule

// File: doc/fc_layer_ctrl.md
# fc_layer_ctrl

Sequencing controller for one fully-connected matrix-vector layer of M outputs by N inputs, with P parallel MAC lanes. It accepts an N-word input vector over a valid/ready handshake and drives the x-memory write port. It then sweeps the shared weight-ROM address space once per output group, issuing accumulator clear/enable with the one-cycle memory read latency accounted for, and streams the P results of each group through a one-hot lane select. It sits beside the `datapath_gen_p*` datapaths inside each generated `fc_*` top and replaces the generic controller where the pipelined timing below is required.

## Interface
- `M`, 8: output neurons; must be a multiple of `P`.
- `N`, 8: input vector length, ≥ 2.
- `T`, 16: data width; passed through for consistency, no internal use.
- `P`, 1: parallel MAC lanes; each lane's ROM holds M·N/P words.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `input_valid` in 1: upstream word valid.
- `input_ready` out 1: controller accepting input words.
- `output_valid` out 1: result word on `output_data` valid.
- `output_ready` in 1: downstream accepts result.
- `addr_x` out $clog2(N): x-memory address (write in LOAD, read in ISSUE).
- `wr_en_x` out 1: x-memory write strobe.
- `addr_w` out $clog2(M·N/P): weight-ROM address, common to all lanes.
- `clear_acc` out 1: zero all lane accumulators.
- `en_acc` out 1: accumulate the product of the current ROM and x read data.
- `f_sel` out P: one-hot lane select for the output mux.

## Operation
- States: LOAD, ISSUE, DRAIN, OUT.
- **LOAD**
  - `input_ready` = 1.
  - `wr_en_x` = `input_valid` (combinational).
  - `addr_x` = load counter k, which advances on each handshake.
  - On the handshake with k = N−1: k ← 0, g ← 0, go to ISSUE.
- **ISSUE**
  - One cycle per k = 0..N−1.
  - `addr_x` = k; `addr_w` = g·N + k.
  - `clear_acc` = 1 only in the cycle with k = 0.
  - `en_acc` = 1 in every ISSUE cycle except k = 0. It is the enable delayed one cycle, matching the registered ROM/x read.
  - After k = N−1, go to DRAIN.
- **DRAIN**
  - One cycle; `en_acc` = 1 for the last product.
  - Go to OUT with lane j = 0.
- **OUT**
  - `output_valid` = 1; `f_sel` = 1 << j.
  - On `output_valid & output_ready`: if j < P−1, j ← j+1.
  - Otherwise, if g < M/P−1: g ← g+1, go to ISSUE.
  - Otherwise go to LOAD.
- Outside the strobe conditions above, `wr_en_x`, `clear_acc` and `en_acc` are 0. `input_ready` is 0 outside LOAD.
- Because `clear_acc` and the first product arrive in consecutive cycles, the datapath sees a clear followed by N enables per group.
- Counter widths:
  - k: $clog2(N)
  - g: $clog2(M/P)+1
  - j: $clog2(P)+1
- Address arithmetic is unsigned and never exceeds M·N/P−1. No wrap occurs inside a layer pass.

## Timing
- Reset (synchronous): at the first edge with `reset` high, the state becomes LOAD with k = g = j = 0.
- Output values after that edge: `input_ready` = 1; `output_valid` = 0; `wr_en_x` = 0 unless `input_valid`; `clear_acc` = 0; `en_acc` = 0; `addr_x` = 0; `addr_w` = 0; `f_sel` = 1.
- A reset mid-ISSUE or mid-OUT abandons the pass. Any partially loaded vector is discarded.
- Latency: the first `output_valid` is asserted N+1 cycles after the cycle of the last input handshake, ignoring backpressure.
- `output_valid` stays high and `f_sel` stays stable until `output_ready`. Backpressure stalls only OUT.
- `input_valid` is ignored outside LOAD. No input is accepted while results are pending.
- Per-vector throughput with `output_ready` tied high: N + (M/P)·(N+1+P) cycles.

## Structure
- Package `fc_ctrl_pkg` holds:
  - the `fc_state_t` enum (LOAD, ISSUE, DRAIN, OUT);
  - helper functions for the counter widths.
- Sub-module `fc_addr_gen` holds the k/g counters and produces `addr_x`/`addr_w`. The FSM instantiates it and owns j, the handshakes and the strobes.

## Test plan
- M=8, N=8, P=1, reset, then 8 back-to-back inputs:
  - `wr_en_x` high 8 cycles at `addr_x` 0..7;
  - `addr_w` steps 0..7 with `clear_acc` in the first ISSUE cycle;
  - `output_valid` exactly 9 cycles after the last input.
- Same configuration with `output_ready` = 1: `addr_w` bases 0, 8, …, 56 across eight groups, and 8 output handshakes before `input_ready` returns.
- M=8, N=8, P=2:
  - `addr_w` spans 0..31;
  - each group yields two outputs with `f_sel` = 01 then 10;
  - 4 groups total.
- `output_ready` low for 5 cycles in OUT: `output_valid` and `f_sel` hold, no address or strobe changes, and `input_valid` pulses are not accepted.
- `input_valid` gapped in LOAD (valid every third cycle): `wr_en_x` asserts only on valid cycles and `addr_x` advances only on handshakes.
- `reset` asserted during the fourth ISSUE cycle: the next cycle shows LOAD, `input_ready` = 1, `en_acc` = 0, `addr_w` = 0. A subsequent full vector then produces correct, uncorrupted sequencing.
